// File: rtl/zoom_pkg.sv
// Shared types and frame-size helpers for the zoom output stream stages.
// Used by zoom_stream_fifo and zoom_frame_streamer.
package zoom_pkg;

  localparam int DATA_W = 8;

  function automatic int out_width(input int largura, input int zoom);
    return largura * zoom;
  endfunction

  function automatic int out_height(input int altura, input int zoom);
    return altura * zoom;
  endfunction

  function automatic int frame_pixels(input int largura, input int altura, input int zoom);
    return out_width(largura, zoom) * out_height(altura, zoom);
  endfunction

  // Smallest address width that can reach every pixel of an n-pixel frame.
  function automatic int min_addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] pixel;
    logic              sof;
    logic              eol;
    logic              eof;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/zoom_stream_fifo.sv
// Two-entry FIFO of pixel beats; push and pop in the same cycle keep the count
// unchanged and preserve order.
module zoom_stream_fifo
  import zoom_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // Entries reset to zero so an empty FIFO presents a zero head beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_beat;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/zoom_frame_streamer.sv
// Reads the zoomed frame buffer in raster order and emits it as a valid/ready stream
// with sof/eol/eof markers. Define ZOOM_STREAM_CHECKSUM_EN to add the frame_sum output.
module zoom_frame_streamer
  import zoom_pkg::*;
#(
  parameter int largura  = 2,
  parameter int altura   = 2,
  parameter int zoom     = 2,
  parameter int nlargura = out_width(largura, zoom),
  parameter int naltura  = out_height(altura, zoom),
  parameter int DATA_W   = zoom_pkg::DATA_W,
  parameter int ADDR_W   = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof
`ifdef ZOOM_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]       frame_sum
`endif
);

  localparam int                N         = nlargura * naltura;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(nlargura - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              inflight_q;
  logic [2:0]        tag_q;
  beat_t             push_beat;
  beat_t             head;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        occupancy;

  assign pop       = out_valid && out_ready;
  // The slot freed by this cycle's pop counts as space, keeping one pixel per cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = (occupancy < 3'd2);
        if (rd_en) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && head.eof) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are captured from the issuing address so they travel with the returning data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= rd_en;
      if (rd_en) begin
        tag_q <= {addr_q == '0, col_q == LAST_COL, addr_q == LAST_ADDR};
      end
    end
  end

  assign push_beat = '{pixel: rd_data, sof: tag_q[2], eol: tag_q[1], eof: tag_q[0]};

  zoom_stream_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign rd_addr   = addr_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_pixel = head.pixel;
  assign out_sof   = out_valid && head.sof;
  assign out_eol   = out_valid && head.eol;
  assign out_eof   = out_valid && head.eof;

`ifdef ZOOM_STREAM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (state_q == IDLE && start) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + 16'(head.pixel);
    end
  end

  assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_zoom_frame_streamer.sv
// Self-checking bench for zoom_frame_streamer: table of frame scenarios against a
// raster-order reference model, plus reset, mid-frame reset and a 3x6 variant.
`timescale 1ns/1ps
module tb_zoom_frame_streamer;

  localparam int NL = 4, NA = 4, N = 16;
  localparam int NLB = 3, NB = 18;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start, busy, done, rdEn, outValid, outReady, outSof, outEol, outEof;
  logic [10:0] rdAddr;
  logic [7:0]  rdData, outPixel;
  logic        bStart, bBusy, bDone, bRdEn, bOutValid, bOutReady, bOutSof, bOutEol, bOutEof;
  logic [10:0] bRdAddr;
  logic [7:0]  bRdData, bOutPixel;
`ifdef ZOOM_STREAM_CHECKSUM_EN
  logic [15:0] frameSum, bFrameSum;
`endif

  logic [7:0] memA [2048];
  logic [7:0] memB [2048];

  always @(posedge clock) if (rdEn) rdData <= memA[rdAddr];
  always @(posedge clock) if (bRdEn) bRdData <= memB[bRdAddr];

  zoom_frame_streamer #(.largura(2), .altura(2), .zoom(2)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData),
    .out_valid(outValid), .out_ready(outReady), .out_pixel(outPixel),
    .out_sof(outSof), .out_eol(outEol), .out_eof(outEof)
`ifdef ZOOM_STREAM_CHECKSUM_EN
    , .frame_sum(frameSum)
`endif
  );

  zoom_frame_streamer #(.largura(1), .altura(2), .zoom(3)) dutB (
    .clock(clock), .reset(reset), .start(bStart), .busy(bBusy), .done(bDone),
    .rd_en(bRdEn), .rd_addr(bRdAddr), .rd_data(bRdData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_pixel(bOutPixel),
    .out_sof(bOutSof), .out_eol(bOutEol), .out_eof(bOutEof)
`ifdef ZOOM_STREAM_CHECKSUM_EN
    , .frame_sum(bFrameSum)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int readyPct;
    bit dblStart;
    int fill;
    int expPixels;
    int expDone;
    int expFirst;
    int expSum;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int expFlags(input int i, input int nl, input int n);
    return {i == 0, (i % nl) == nl - 1, i == n - 1};
  endfunction

  // Streams one frame from DUT A, checking every accepted beat against the model.
  task automatic applyStimulus(input int readyPct, input bit dblStart, output int nPix,
                               output int nDone, output int firstIdx, output int lastIdx,
                               output int sum);
    bit prevStall = 0, seenDone = 0, finished = 0;
    int prevPix = 0, prevFl = 0, outstanding = 0, tail = 0;
    nPix = 0; nDone = 0; firstIdx = -1; lastIdx = -1; sum = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clock);
      start    = (cyc == 0) || (dblStart && cyc == 8);
      outReady = ($urandom_range(99) < readyPct);
      #1;
      if (prevStall) begin
        checkOutput("stall_valid", outValid, 1);
        checkOutput("stall_pixel", outPixel, prevPix);
        checkOutput("stall_flags", {outSof, outEol, outEof}, prevFl);
      end
      if (cyc == 1) begin
        checkOutput("first_read_addr0", {rdEn, rdAddr}, {1'b1, 11'd0});
        checkOutput("busy_running", busy, 1);
      end
      if (outValid && firstIdx < 0) firstIdx = cyc;
      if (outValid && outReady) begin
        if (nPix < N) begin
          checkOutput("pixel", outPixel, memA[nPix]);
          checkOutput("flags", {outSof, outEol, outEof}, expFlags(nPix, NL, N));
        end else begin
          checkOutput("extra_pixel", nPix, N - 1);
        end
        sum = (sum + outPixel) % 65536;
        nPix++;
        lastIdx = cyc;
        outstanding--;
      end
      if (rdEn) begin
        outstanding++;
        checkOutput("no_read_when_full", outstanding <= 2, 1);
      end
      if (done) begin
        nDone++;
        seenDone = 1;
      end
      if (seenDone) begin
        tail++;
        if (tail == 4) finished = 1;
      end
      prevStall = outValid && !outReady;
      prevPix   = outPixel;
      prevFl    = {outSof, outEol, outEof};
    end
    if (!finished) checkOutput("frame_timeout", finished, 1);
    start = 1'b0;
    checkOutput("busy_after_done", busy, 0);
  endtask

  task automatic fillA(input int fill);
    for (int i = 0; i < N; i++)
      memA[i] = (fill == 0) ? 8'(i + 1) : (fill == 1) ? 8'd255 : 8'($urandom_range(255));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {busy, done, rdEn, outValid, outSof, outEol, outEof}, 0);
    checkOutput({tag, "_rd_addr"}, rdAddr, 0);
    checkOutput({tag, "_pixel"}, outPixel, 0);
  endtask

  vec_t vecs[5];
  int nPix, nDone, firstIdx, lastIdx, sum;

  initial begin
    vecs[0] = '{100, 0, 0, 16, 1, 3, 136};
    vecs[1] = '{50, 0, 0, 16, 1, 3, 136};
    vecs[2] = '{50, 1, 0, 16, 1, 3, 136};
    vecs[3] = '{100, 0, 1, 16, 1, 3, 4080};
    vecs[4] = '{30, 0, 2, 16, 1, 3, -1};
    for (int i = 0; i < 2048; i++) begin
      memA[i] = 8'd0;
      memB[i] = 8'(i + 50);
    end

    reset = 1'b0; start = 0; outReady = 0; bStart = 0; bOutReady = 0;
    #1;
    checkAllZero("reset");
    checkOutput("reset_b_ctrl", {bBusy, bDone, bRdEn, bOutValid}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      fillA(vecs[v].fill);
      applyStimulus(vecs[v].readyPct, vecs[v].dblStart, nPix, nDone, firstIdx, lastIdx, sum);
      $display("[TB] scenario %0d ready=%0d%% pixels=%0d", v, vecs[v].readyPct, nPix);
      checkOutput("pixel_count", nPix, vecs[v].expPixels);
      checkOutput("done_pulses", nDone, vecs[v].expDone);
      checkOutput("first_valid_latency", firstIdx, vecs[v].expFirst);
      if (vecs[v].readyPct == 100) checkOutput("back_to_back", lastIdx - firstIdx, N - 1);
`ifdef ZOOM_STREAM_CHECKSUM_EN
      checkOutput("frame_sum_model", frameSum, sum);
      if (vecs[v].expSum >= 0) checkOutput("frame_sum_const", frameSum, vecs[v].expSum);
`endif
    end

    // Mid-frame reset after the fifth accepted pixel.
    fillA(0);
    nPix = 0;
    @(negedge clock);
    start = 1; outReady = 1;
    for (int cyc = 0; cyc < 50 && nPix < 5; cyc++) begin
      if (cyc > 0) @(negedge clock);
      start = (cyc == 0);
      #1;
      if (outValid && outReady) nPix++;
    end
    checkOutput("pre_reset_pixels", nPix, 5);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkAllZero("midframe_reset");
    nDone = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      if (done) nDone++;
    end
    reset = 1'b1;
    @(negedge clock);
    if (done) nDone++;
    checkOutput("no_done_after_abort", nDone, 0);
    applyStimulus(100, 0, nPix, nDone, firstIdx, lastIdx, sum);
    checkOutput("restart_pixel_count", nPix, N);
    checkOutput("restart_done", nDone, 1);

    // 1x2 source at zoom 3: 3 columns by 6 rows.
    begin
      bit fin = 0, seen = 0;
      int tail = 0;
      nPix = 0; nDone = 0; firstIdx = -1; sum = 0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
        @(negedge clock);
        bStart = (cyc == 0);
        bOutReady = 1'b1;
        #1;
        if (bOutValid && firstIdx < 0) firstIdx = cyc;
        if (bOutValid && bOutReady) begin
          if (nPix < NB) begin
            checkOutput("var_pixel", bOutPixel, memB[nPix]);
            checkOutput("var_flags", {bOutSof, bOutEol, bOutEof}, expFlags(nPix, NLB, NB));
          end else begin
            checkOutput("var_extra_pixel", nPix, NB - 1);
          end
          sum = (sum + bOutPixel) % 65536;
          nPix++;
        end
        if (bDone) begin
          nDone++;
          seen = 1;
        end
        if (seen) begin
          tail++;
          if (tail == 3) fin = 1;
        end
      end
      if (!fin) checkOutput("var_timeout", fin, 1);
      checkOutput("var_pixel_count", nPix, NB);
      checkOutput("var_done", nDone, 1);
      checkOutput("var_first_latency", firstIdx, 3);
      checkOutput("var_busy_after", bBusy, 0);
`ifdef ZOOM_STREAM_CHECKSUM_EN
      checkOutput("var_frame_sum", bFrameSum, sum);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
